// File: rtl/regfile_loader.sv
// rtl/regfile_loader.sv - byte-stream / zero-fill loader driving a registered register-file write port
// Single FSM: stream bytes from a base address (with wrap) or zero-fill all entries.
module regfile_loader #(
  parameter int DATA_W = 8,
  parameter int ADR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear_mode,
  input  logic [ADR_W-1:0]  base_adr,
  input  logic [ADR_W:0]    count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADR_W-1:0]  wadr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [ADR_W:0]    written_cnt
);

  localparam logic [ADR_W:0] DEPTH_C = {1'b1, {ADR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} state_t;

  state_t              state_q;
  logic [ADR_W-1:0]    ptr_q;
  logic [ADR_W:0]      rem_q;
  logic [ADR_W:0]      cnt_q;
  logic                we_q;
  logic [ADR_W-1:0]    wadr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                busy_q;
  logic                done_q;
  logic [ADR_W:0]      rem_d;

  // Requests longer than the file are clamped so every entry is written at most once.
  assign rem_d = (count > DEPTH_C) ? DEPTH_C : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wadr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q <= clear_mode ? '0 : base_adr;
            rem_q <= rem_d;
            cnt_q <= '0;
            if (clear_mode) begin
              state_q <= CLEAR;
              busy_q  <= 1'b1;
            end else if (rem_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
              busy_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            we_q    <= 1'b1;
            wadr_q  <= ptr_q;
            wdata_q <= in_data;
            ptr_q   <= ptr_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            cnt_q   <= cnt_q + 1'b1;
            if (rem_q == {{ADR_W{1'b0}}, 1'b1}) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          we_q    <= 1'b1;
          wadr_q  <= ptr_q;
          wdata_q <= '0;
          ptr_q   <= ptr_q + 1'b1;
          cnt_q   <= cnt_q + 1'b1;
          if (ptr_q == {ADR_W{1'b1}}) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == LOAD);
  assign we          = we_q;
  assign wadr        = wadr_q;
  assign wdata       = wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign written_cnt = cnt_q;

endmodule
